// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit arbiter.
package eth_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 64;

    // Byte-enable width for a given tdata width.
    function automatic int unsigned keep_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_XFER  = 3'd1,
        ST_ABORT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_GAP   = 3'd4
    } arb_state_e;

    // Terminating beat sent to the MAC when a source stalls mid-frame.
    localparam logic [7:0] ABORT_TKEEP = 8'h01;
    localparam logic       ABORT_TUSER = 1'b1;

endpackage

// File: rtl/eth_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_i, with wrap.
module rr_arbiter #(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned IDXW   = 2
) (
    input  logic [NPORTS-1:0] req_i,
    input  logic [IDXW-1:0]   last_i,
    output logic [IDXW-1:0]   grant_o,
    output logic              valid_o
);

    int dist_c;
    int best_c;

    // Pick the requester with the smallest distance from last_i+1.
    always_comb begin
        grant_o = last_i;
        valid_o = 1'b0;
        dist_c  = 0;
        best_c  = int'(NPORTS);
        for (int p = 0; p < int'(NPORTS); p++) begin
            dist_c = (p + int'(NPORTS) - 1 - int'(last_i)) % int'(NPORTS);
            if (req_i[p] && (dist_c < best_c)) begin
                best_c  = dist_c;
                grant_o = IDXW'(p);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// N-port AXI-Stream transmit arbiter: whole-frame round-robin, idle gap, stall abort.
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int unsigned NPORTS      = 4,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned GAP_CYCLES  = 0,
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic                                        clk156,
    input  logic                                        eth_rst,
    input  logic [NPORTS-1:0]                           s_axis_tx_tvalid,
    output logic [NPORTS-1:0]                           s_axis_tx_tready,
    input  logic [NPORTS*DATA_WIDTH-1:0]                s_axis_tx_tdata,
    input  logic [NPORTS*DATA_WIDTH/8-1:0]              s_axis_tx_tkeep,
    input  logic [NPORTS-1:0]                           s_axis_tx_tlast,
    input  logic [NPORTS-1:0]                           s_axis_tx_tuser,
    output logic                                        m_axis_tx_tvalid,
    input  logic                                        m_axis_tx_tready,
    output logic [DATA_WIDTH-1:0]                       m_axis_tx_tdata,
    output logic [DATA_WIDTH/8-1:0]                     m_axis_tx_tkeep,
    output logic                                        m_axis_tx_tlast,
    output logic                                        m_axis_tx_tuser,
    output logic [((NPORTS > 1) ? $clog2(NPORTS) : 1)-1:0] grant_port,
    output logic                                        busy,
    output logic [15:0]                                 abort_count
);

    localparam int unsigned KW   = keep_width(DATA_WIDTH);
    localparam int unsigned IDXW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int unsigned STW  = $clog2(STALL_LIMIT + 1);

    arb_state_e       state_q, state_d;
    logic [IDXW-1:0]  grant_q, grant_d;
    logic [IDXW-1:0]  last_q, last_d;
    logic [STW-1:0]   stall_q, stall_d;
    logic [7:0]       gap_q, gap_d;
    logic [15:0]      abort_q, abort_d;
    logic             busy_q, busy_d;

    logic [IDXW-1:0]  rr_grant_c;
    logic             rr_valid_c;

    logic [NPORTS-1:0]     grant_oh_c;
    logic                  sel_valid_c;
    logic                  sel_last_c;
    logic                  sel_user_c;
    logic [DATA_WIDTH-1:0] sel_data_c;
    logic [KW-1:0]         sel_keep_c;

    rr_arbiter #(
        .NPORTS (NPORTS),
        .IDXW   (IDXW)
    ) u_rr (
        .req_i   (s_axis_tx_tvalid),
        .last_i  (last_q),
        .grant_o (rr_grant_c),
        .valid_o (rr_valid_c)
    );

    // Mux the currently granted source onto a single set of signals.
    always_comb begin
        grant_oh_c  = '0;
        sel_valid_c = 1'b0;
        sel_last_c  = 1'b0;
        sel_user_c  = 1'b0;
        sel_data_c  = '0;
        sel_keep_c  = '0;
        for (int p = 0; p < int'(NPORTS); p++) begin
            if (grant_q == IDXW'(p)) begin
                grant_oh_c[p] = 1'b1;
                sel_valid_c   = s_axis_tx_tvalid[p];
                sel_last_c    = s_axis_tx_tlast[p];
                sel_user_c    = s_axis_tx_tuser[p];
                sel_data_c    = s_axis_tx_tdata[p*DATA_WIDTH +: DATA_WIDTH];
                sel_keep_c    = s_axis_tx_tkeep[p*KW +: KW];
            end
        end
    end

    // Next-state and master/slave handshake outputs.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_d           = last_q;
        stall_d          = stall_q;
        gap_d            = gap_q;
        abort_d          = abort_q;
        s_axis_tx_tready = '0;
        m_axis_tx_tvalid = 1'b0;
        m_axis_tx_tdata  = '0;
        m_axis_tx_tkeep  = '0;
        m_axis_tx_tlast  = 1'b0;
        m_axis_tx_tuser  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rr_valid_c) begin
                    grant_d = rr_grant_c;
                    last_d  = rr_grant_c;
                    stall_d = '0;
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                m_axis_tx_tvalid = sel_valid_c;
                m_axis_tx_tdata  = sel_data_c;
                m_axis_tx_tkeep  = sel_keep_c;
                m_axis_tx_tlast  = sel_last_c;
                m_axis_tx_tuser  = sel_user_c;
                s_axis_tx_tready = grant_oh_c & {NPORTS{m_axis_tx_tready}};
                if (sel_valid_c) begin
                    // MAC backpressure keeps the source valid, so it never counts as a stall.
                    stall_d = '0;
                    if (m_axis_tx_tready && sel_last_c) begin
                        if (GAP_CYCLES > 0) begin
                            state_d = ST_GAP;
                            gap_d   = 8'(GAP_CYCLES);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (stall_q == STW'(STALL_LIMIT - 1)) begin
                    state_d = ST_ABORT;
                end else begin
                    stall_d = stall_q + STW'(1);
                end
            end

            ST_ABORT: begin
                m_axis_tx_tvalid = 1'b1;
                m_axis_tx_tkeep  = KW'(ABORT_TKEEP);
                m_axis_tx_tlast  = 1'b1;
                m_axis_tx_tuser  = ABORT_TUSER;
                if (m_axis_tx_tready) begin
                    if (abort_q != 16'hFFFF) begin
                        abort_d = abort_q + 16'd1;
                    end
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                s_axis_tx_tready = grant_oh_c;
                if (sel_valid_c && sel_last_c) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        gap_d   = 8'(GAP_CYCLES);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_GAP: begin
                if (gap_q <= 8'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDXW'(NPORTS - 1);
            stall_q <= '0;
            gap_q   <= '0;
            abort_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            stall_q <= stall_d;
            gap_q   <= gap_d;
            abort_q <= abort_d;
            busy_q  <= busy_d;
        end
    end

    assign grant_port  = grant_q;
    assign busy        = busy_q;
    assign abort_count = abort_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter (4 ports, gap 3, stall limit 8).
module tb_eth_tx_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int KW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    typedef struct {
        logic          tv;
        logic [DW-1:0] d;
        logic          last;
        logic          mr;
        logic          e_mv;
        logic [DW-1:0] e_d;
        logic          e_last;
        logic [NP-1:0] e_str;
        logic          e_busy;
    } vec_t;

    logic clk156 = 1'b0;
    logic eth_rst;
    logic [NP-1:0]    s_tv, s_tr, s_tl, s_tu;
    logic [NP*DW-1:0] s_td;
    logic [NP*KW-1:0] s_tk;
    logic             m_tv, m_tr, m_tl, m_tu;
    logic [DW-1:0]    m_td;
    logic [KW-1:0]    m_tk;
    logic [1:0]       grant_port;
    logic             busy;
    logic [15:0]      abort_count;

    int total = 0;
    int bad   = 0;

    beat_t src_q[NP][$];
    beat_t exp_q[NP][$];
    int    gseq[$];
    int    gaps[$];
    int    tlast_cnt;
    int    prev_g;

    always #5 clk156 = ~clk156;

    eth_tx_arbiter #(
        .NPORTS      (NP),
        .DATA_WIDTH  (DW),
        .GAP_CYCLES  (3),
        .STALL_LIMIT (8)
    ) dut (
        .clk156           (clk156),
        .eth_rst          (eth_rst),
        .s_axis_tx_tvalid (s_tv),
        .s_axis_tx_tready (s_tr),
        .s_axis_tx_tdata  (s_td),
        .s_axis_tx_tkeep  (s_tk),
        .s_axis_tx_tlast  (s_tl),
        .s_axis_tx_tuser  (s_tu),
        .m_axis_tx_tvalid (m_tv),
        .m_axis_tx_tready (m_tr),
        .m_axis_tx_tdata  (m_td),
        .m_axis_tx_tkeep  (m_tk),
        .m_axis_tx_tlast  (m_tl),
        .m_axis_tx_tuser  (m_tu),
        .grant_port       (grant_port),
        .busy             (busy),
        .abort_count      (abort_count)
    );

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic clr_inputs();
        s_tv = '0;
        s_td = '0;
        s_tk = '0;
        s_tl = '0;
        s_tu = '0;
    endtask

    task automatic put(input int p, input logic v, input logic [DW-1:0] d, input logic l);
        s_tv[p]          = v;
        s_td[p*DW +: DW] = d;
        s_tk[p*KW +: KW] = 8'hFF;
        s_tl[p]          = l;
        s_tu[p]          = 1'b0;
    endtask

    task automatic gen_frame(input int p, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = {$urandom, $urandom};
            b.last = (k == len - 1);
            b.keep = b.last ? (8'($urandom) | 8'h01) : 8'hFF;
            b.user = ($urandom_range(7) == 0);
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
    endtask

    // Drives per-port frame queues as AXI sources, scores the master side per port
    // and checks every grant against the round-robin rule.
    task automatic run_engine(input int vpct, input int rpct, input int budget);
        logic [NP-1:0] s_acc, req_prev, midf;
        int    gapc[NP];
        logic  fr_started, gap_active, done;
        int    gap_len, cyc, exp_g, q;
        beat_t b, e;
        s_acc      = '0;
        req_prev   = s_tv;
        midf       = '0;
        fr_started = 1'b0;
        gap_active = 1'b0;
        gap_len    = 0;
        cyc        = 0;
        done       = 1'b0;
        for (int p = 0; p < NP; p++) gapc[p] = 0;
        gseq.delete();
        gaps.delete();
        tlast_cnt = 0;
        while (!done) begin
            @(posedge clk156);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (s_acc[p]) begin
                    b = src_q[p].pop_front();
                    midf[p] = !b.last;
                    s_tv[p] = 1'b0;
                    gapc[p] = 0;
                end
                if (src_q[p].size() == 0) begin
                    s_tv[p] = 1'b0;
                end else if (!s_tv[p]) begin
                    if ((midf[p] && gapc[p] >= 4) || (int'($urandom_range(99)) < vpct)) s_tv[p] = 1'b1;
                    else gapc[p]++;
                end
                if (src_q[p].size() != 0) begin
                    b = src_q[p][0];
                    s_td[p*DW +: DW] = b.data;
                    s_tk[p*KW +: KW] = b.keep;
                    s_tl[p]          = b.last;
                    s_tu[p]          = b.user;
                end
            end
            m_tr = (int'($urandom_range(99)) < rpct);
            @(negedge clk156);
            if (m_tv && !fr_started) begin
                fr_started = 1'b1;
                exp_g = -1;
                for (int k = 1; k <= NP; k++) begin
                    q = (prev_g + k) % NP;
                    if (exp_g < 0 && req_prev[q]) exp_g = q;
                end
                chk("rr_grant", 80'(grant_port), 80'(exp_g));
                prev_g = int'(grant_port);
                gseq.push_back(prev_g);
                if (gap_active) gaps.push_back(gap_len);
                gap_active = 1'b0;
            end else if (!m_tv && gap_active) begin
                gap_len++;
            end
            if (m_tv && m_tr) begin
                if (exp_q[grant_port].size() == 0) begin
                    chk("unexpected_beat", 80'({m_td, m_tk, m_tl, m_tu}), 80'(0));
                end else begin
                    e = exp_q[grant_port].pop_front();
                    chk("beat", 80'({m_td, m_tk, m_tl, m_tu}), 80'(e));
                end
                if (m_tl) begin
                    fr_started = 1'b0;
                    tlast_cnt++;
                    gap_active = 1'b1;
                    gap_len    = 0;
                end
            end
            s_acc    = s_tv & s_tr;
            req_prev = s_tv;
            cyc++;
            done = 1'b1;
            for (int p = 0; p < NP; p++)
                if (src_q[p].size() != 0 || exp_q[p].size() != 0) done = 1'b0;
            if (!done && cyc >= budget) begin
                chk("engine_timeout", 80'(cyc), 80'(0));
                done = 1'b1;
            end
        end
        @(posedge clk156);
        #1;
        clr_inputs();
        m_tr = 1'b1;
        repeat (6) @(posedge clk156);
    endtask

    initial begin
        vec_t      vt[22];
        logic [DW-1:0] bd[5];
        int n;

        // Port 0 frame under toggling and long MAC backpressure.
        bd[0] = 64'h1111_0000_0000_0001;
        bd[1] = 64'h2222_0000_0000_0002;
        bd[2] = 64'h3333_0000_0000_0003;
        bd[3] = 64'h4444_0000_0000_0004;
        bd[4] = 64'h5555_0000_0000_0005;
        vt[0]  = '{1'b1, bd[0], 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 4'b0000, 1'b0};
        vt[1]  = '{1'b1, bd[0], 1'b0, 1'b1, 1'b1, bd[0], 1'b0, 4'b0001, 1'b1};
        vt[2]  = '{1'b1, bd[1], 1'b0, 1'b0, 1'b1, bd[1], 1'b0, 4'b0000, 1'b1};
        vt[3]  = '{1'b1, bd[1], 1'b0, 1'b1, 1'b1, bd[1], 1'b0, 4'b0001, 1'b1};
        for (int i = 4; i <= 14; i++)
            vt[i] = '{1'b1, bd[2], 1'b0, 1'b0, 1'b1, bd[2], 1'b0, 4'b0000, 1'b1};
        vt[15] = '{1'b1, bd[2], 1'b0, 1'b1, 1'b1, bd[2], 1'b0, 4'b0001, 1'b1};
        vt[16] = '{1'b1, bd[3], 1'b1, 1'b0, 1'b1, bd[3], 1'b1, 4'b0000, 1'b1};
        vt[17] = '{1'b1, bd[3], 1'b1, 1'b1, 1'b1, bd[3], 1'b1, 4'b0001, 1'b1};
        for (int i = 18; i <= 20; i++)
            vt[i] = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 4'b0000, 1'b1};
        vt[21] = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 4'b0000, 1'b0};

        clr_inputs();
        m_tr    = 1'b0;
        eth_rst = 1'b1;
        repeat (3) @(posedge clk156);
        #1;
        eth_rst = 1'b0;
        @(negedge clk156);
        chk("reset_state", 80'({m_tv, m_tl, m_tu, s_tr, grant_port, busy, abort_count}), 80'(0));

        // Simultaneous 4-beat frames on ports 0 and 2.
        gen_frame(0, 4);
        gen_frame(2, 4);
        prev_g = 3;
        run_engine(100, 100, 200);
        chk("A_order", 80'({(gseq.size() > 0) ? gseq[0] : 99, (gseq.size() > 1) ? gseq[1] : 99}),
            80'({32'd0, 32'd2}));
        chk("A_tlasts", 80'(tlast_cnt), 80'(2));

        // Back-to-back 2-beat frames on port 1: gap of 3 plus one idle cycle.
        for (int i = 0; i < 3; i++) gen_frame(1, 2);
        prev_g = 2;
        run_engine(100, 100, 300);
        chk("B_tlasts", 80'(tlast_cnt), 80'(3));
        chk("B_gap_count", 80'(gaps.size()), 80'(2));
        foreach (gaps[i]) chk($sformatf("B_gap%0d", i), 80'(gaps[i]), 80'(4));
        foreach (gseq[i]) chk($sformatf("B_grant%0d", i), 80'(gseq[i]), 80'(1));

        // Table-driven backpressure passthrough on port 0.
        for (int i = 0; i < 22; i++) begin
            @(posedge clk156);
            #1;
            clr_inputs();
            put(0, vt[i].tv, vt[i].d, vt[i].last);
            m_tr = vt[i].mr;
            @(negedge clk156);
            chk($sformatf("vec%0d", i), 80'({m_tv, m_td, m_tl, s_tr, busy}),
                80'({vt[i].e_mv, vt[i].e_d, vt[i].e_last, vt[i].e_str, vt[i].e_busy}));
        end
        chk("C_no_abort", 80'(abort_count), 80'(0));

        // Port 3 stalls 8 cycles mid-frame: abort beat, then drain.
        for (int c = 0; c < 19; c++) begin
            @(posedge clk156);
            #1;
            m_tr = 1'b1;
            if (c <= 1)       put(3, 1'b1, bd[0], 1'b0);
            else if (c == 2)  put(3, 1'b1, bd[1], 1'b0);
            else if (c <= 10) put(3, 1'b0, 64'd0, 1'b0);
            else if (c <= 12) put(3, 1'b1, bd[2], 1'b0);
            else if (c == 13) put(3, 1'b1, bd[3], 1'b0);
            else if (c == 14) put(3, 1'b1, bd[4], 1'b1);
            else              put(3, 1'b0, 64'd0, 1'b0);
            @(negedge clk156);
            if (c == 1)  chk("D_grant", 80'(grant_port), 80'(3));
            if (c == 10) chk("D_pre_abort", 80'(m_tv), 80'(0));
            if (c == 11) chk("D_abort_beat", 80'({m_tv, m_td, m_tk, m_tl, m_tu, s_tr}),
                             80'({1'b1, 64'd0, 8'h01, 1'b1, 1'b1, 4'b0000}));
            if (c >= 12 && c <= 14) chk($sformatf("D_drain%0d", c), 80'({m_tv, s_tr}), 80'({1'b0, 4'b1000}));
            if (c == 12) chk("D_abort_count", 80'(abort_count), 80'(1));
            if (c == 15) chk("D_gap", 80'({m_tv, s_tr, busy}), 80'({1'b0, 4'b0000, 1'b1}));
            if (c == 18) chk("D_idle", 80'(busy), 80'(0));
        end

        // Reset during beat 3 of a port 1 frame; pointer must restart at port 0.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk156);
            #1;
            if (c <= 1)      put(1, 1'b1, bd[0], 1'b0);
            else if (c == 2) put(1, 1'b1, bd[1], 1'b0);
            else if (c == 3) begin
                put(1, 1'b1, bd[2], 1'b0);
                eth_rst = 1'b1;
            end else begin
                eth_rst = 1'b0;
                clr_inputs();
            end
            @(negedge clk156);
            if (c == 1) chk("E_grant", 80'(grant_port), 80'(1));
            if (c == 4) chk("E_reset_vals", 80'({m_tv, m_tl, m_tu, s_tr, grant_port, busy, abort_count}), 80'(0));
        end
        gen_frame(0, 1);
        gen_frame(2, 1);
        prev_g = 3;
        run_engine(100, 100, 200);
        chk("E_order", 80'({(gseq.size() > 0) ? gseq[0] : 99, (gseq.size() > 1) ? gseq[1] : 99}),
            80'({32'd0, 32'd2}));

        // 1000 random frames from all ports with random gaps and backpressure.
        for (int i = 0; i < 250; i++)
            for (int p = 0; p < NP; p++) gen_frame(p, int'($urandom_range(6, 1)));
        prev_g = 2;
        run_engine(60, 75, 60000);
        n = tlast_cnt;
        chk("F_frames", 80'(n), 80'(1000));
        chk("F_no_abort", 80'(abort_count), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
